// File: rtl/uart_cmd_ctrl_if.sv
// Byte-level link between the UART receiver/transmitter, the command controller and the watch datapath.
// The master modport is the controller side; the slave modport is the UART/datapath side.
interface uart_cmd_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       btn_run;
    logic       btn_clear;
    logic       btn_mode;
    logic       run_state;
    logic       cmd_err;
    logic       overrun;

    modport master (
        input  rx_data, rx_done, tx_busy,
        output tx_start, tx_data, btn_run, btn_clear, btn_mode, run_state, cmd_err, overrun
    );

    modport slave (
        output rx_data, rx_done, tx_busy,
        input  tx_start, tx_data, btn_run, btn_clear, btn_mode, run_state, cmd_err, overrun
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Decodes received command bytes into one-cycle button pulses and echoes {byte|'?', LF} back out.
// Pulses one cycle after rx_done, first echo start one cycle later; one pending byte buffered, further bytes dropped with overrun.
module uart_cmd_ctrl #(
    parameter int ECHO_EN     = 1,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    uart_cmd_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, DECODE, TX_START, TX_WAIT, TX_NEXT} state_t;

    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_QM   = 8'h3F;
    localparam logic [4:0] TO_LAST = 5'(ACK_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cmd_reg_q, cmd_reg_d;
    logic       cmd_bad_q, cmd_bad_d;
    logic [7:0] pend_q, pend_d;
    logic       pend_valid_q, pend_valid_d;
    logic       second_q, second_d;
    logic       seen_busy_q, seen_busy_d;
    logic [4:0] cnt_q, cnt_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       btn_run_q, btn_run_d;
    logic       btn_clear_q, btn_clear_d;
    logic       btn_mode_q, btn_mode_d;
    logic       run_state_q, run_state_d;
    logic       cmd_err_q, cmd_err_d;
    logic       overrun_q, overrun_d;
    logic [7:0] pick;

    always_comb begin
        state_d      = state_q;
        cmd_reg_d    = cmd_reg_q;
        cmd_bad_d    = cmd_bad_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        second_d     = second_q;
        seen_busy_d  = seen_busy_q;
        cnt_d        = cnt_q;
        tx_data_d    = tx_data_q;
        run_state_d  = run_state_q;
        tx_start_d   = 1'b0;
        btn_run_d    = 1'b0;
        btn_clear_d  = 1'b0;
        btn_mode_d   = 1'b0;
        cmd_err_d    = 1'b0;
        overrun_d    = 1'b0;
        pick         = pend_valid_q ? pend_q : bus.rx_data;

        if (state_q != IDLE && bus.rx_done) begin
            if (pend_valid_q) begin
                overrun_d = 1'b1;
            end else begin
                pend_d       = bus.rx_data;
                pend_valid_d = 1'b1;
            end
        end

        // tx_start is raised on the edge that enters TX_START so the request appears in that state's first cycle.
        unique case (state_q)
            IDLE: begin
                if (pend_valid_q || bus.rx_done) begin
                    cmd_reg_d    = pick;
                    cmd_bad_d    = 1'b0;
                    pend_valid_d = pend_valid_q && bus.rx_done;
                    if (pend_valid_q && bus.rx_done) pend_d = bus.rx_data;
                    state_d = DECODE;
                    case (pick)
                        8'h52, 8'h72: begin btn_run_d = 1'b1; run_state_d = !run_state_q; end
                        8'h43, 8'h63: begin btn_clear_d = 1'b1; run_state_d = 1'b0; end
                        8'h4D, 8'h6D: btn_mode_d = 1'b1;
                        default:      begin cmd_err_d = 1'b1; cmd_bad_d = 1'b1; end
                    endcase
                end
            end
            DECODE: begin
                if (ECHO_EN != 0) begin
                    state_d    = TX_START;
                    second_d   = 1'b0;
                    tx_data_d  = cmd_bad_q ? CH_QM : cmd_reg_q;
                    tx_start_d = !bus.tx_busy;
                end else begin
                    state_d = IDLE;
                end
            end
            TX_START: begin
                if (tx_start_q) begin
                    state_d     = TX_WAIT;
                    cnt_d       = 5'd0;
                    seen_busy_d = 1'b0;
                end else if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                end
            end
            TX_WAIT: begin
                if (seen_busy_q) begin
                    if (!bus.tx_busy) state_d = TX_NEXT;
                end else if (bus.tx_busy) begin
                    seen_busy_d = 1'b1;
                end else if (cnt_q >= TO_LAST) begin
                    cmd_err_d = 1'b1;
                    state_d   = TX_NEXT;
                end else if (cnt_q != 5'h1F) begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            TX_NEXT: begin
                if (!second_q) begin
                    second_d   = 1'b1;
                    tx_data_d  = CH_LF;
                    state_d    = TX_START;
                    tx_start_d = !bus.tx_busy;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_reg_q    <= 8'h00;
            cmd_bad_q    <= 1'b0;
            pend_q       <= 8'h00;
            pend_valid_q <= 1'b0;
            second_q     <= 1'b0;
            seen_busy_q  <= 1'b0;
            cnt_q        <= 5'd0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            btn_run_q    <= 1'b0;
            btn_clear_q  <= 1'b0;
            btn_mode_q   <= 1'b0;
            run_state_q  <= 1'b0;
            cmd_err_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_reg_q    <= cmd_reg_d;
            cmd_bad_q    <= cmd_bad_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            second_q     <= second_d;
            seen_busy_q  <= seen_busy_d;
            cnt_q        <= cnt_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            btn_run_q    <= btn_run_d;
            btn_clear_q  <= btn_clear_d;
            btn_mode_q   <= btn_mode_d;
            run_state_q  <= run_state_d;
            cmd_err_q    <= cmd_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.btn_run   = btn_run_q;
    assign bus.btn_clear = btn_clear_q;
    assign bus.btn_mode  = btn_mode_q;
    assign bus.run_state = run_state_q;
    assign bus.cmd_err   = cmd_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter ECHO_EN, default 1, meaning 1 = echo every decoded byte to the transmitter and 0 = no transmit activity.
REQ-002 Parameter ACK_TIMEOUT, default 16, meaning the number of clk cycles to wait for tx_busy to rise after tx_start.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_data  input  8  received byte, valid in the cycle rx_done=1.
REQ-006 rx_done  input  1  one-cycle strobe: new byte available.
REQ-007 tx_busy  input  1  transmitter busy; high from accept of tx_start until stop bit sent.
REQ-008 tx_start  output  1  one-cycle request to transmit tx_data.
REQ-009 tx_data  output  8  byte to transmit, stable while state is TX_START or TX_WAIT.
REQ-010 btn_run, btn_clear, btn_mode  output  1 each  one-cycle command pulses to the stopwatch/watch datapath.
REQ-011 run_state  output  1  level: current run/stop state.
REQ-012 cmd_err  output  1  one-cycle pulse: unrecognised byte.
REQ-013 overrun  output  1  one-cycle pulse: received byte dropped.

Function
REQ-014 Decode table: 0x52/0x72 ('R'/'r') -> btn_run pulse, run_state toggles; 0x43/0x63 ('C'/'c') -> btn_clear pulse, run_state forced 0; 0x4D/0x6D ('M'/'m') -> btn_mode pulse; any other byte -> cmd_err pulse.
REQ-015 FSM states: IDLE, DECODE, TX_START, TX_WAIT, TX_NEXT; all outputs registered.
REQ-016 IDLE: rx_done=1 or pend_valid=1 -> capture the byte in cmd_reg, go to DECODE; the pending byte has priority over a simultaneous rx_done.
REQ-017 A byte sampled by the edge ending cycle N (rx_done high during N) produces its btn_*/cmd_err pulse, high in cycle N+1 for exactly one cycle.
REQ-018 DECODE: with ECHO_EN=1, load the echo queue and go to TX_START; with ECHO_EN=0, go to IDLE.
REQ-019 Echo queue: for a valid command, queue {cmd_reg, 0x0A}; for an error, queue {0x3F '?', 0x0A}.
REQ-020 TX_START: wait while tx_busy=1; when tx_busy=0, drive tx_start=1 for one cycle with tx_data = current queue byte, go to TX_WAIT; earliest tx_start is cycle N+2.
REQ-021 TX_WAIT: wait for tx_busy=1, then for tx_busy=0, then go to TX_NEXT.
REQ-022 TX_WAIT timeout: if tx_busy stays 0 for ACK_TIMEOUT cycles after tx_start, the byte is abandoned, cmd_err pulses once, and the FSM goes to TX_NEXT.
REQ-023 TX_NEXT: if the second byte is not yet sent, go to TX_START; otherwise go to IDLE.
REQ-024 Pending buffer, one entry: rx_done=1 outside IDLE with pend_valid=0 captures rx_data into pend and sets pend_valid.
REQ-025 rx_done=1 outside IDLE with pend_valid=1 pulses overrun; the new byte is dropped and pend is unchanged.
REQ-026 In IDLE with pend_valid=1 and rx_done=1 together, pend is processed, the new byte replaces pend, and pend_valid stays 1; no overrun.
REQ-027 tx_start is never asserted while tx_busy=1, and never in two consecutive cycles.
REQ-028 The timeout counter is 5 bits, saturates, and is cleared on entry to TX_WAIT.

Reset
REQ-029 reset=1 -> state IDLE; tx_start, tx_data, btn_*, cmd_err, overrun, run_state, pend_valid, and counters = 0, effective immediately (asynchronous).
REQ-030 Reset mid-echo aborts the transfer; no tx_start follows reset release until a new byte arrives.

Verification
REQ-031 'R' (0x52) with tx_busy model of 10 cycles -> btn_run in N+1, run_state=1, tx_start with 0x52 at N+2, then tx_start with 0x0A after busy falls.
REQ-032 'r' then 'C' (second byte sent after the echo completes) -> run_state goes 1 then 0, btn_clear pulses once, echoes 0x72,0x0A,0x43,0x0A.
REQ-033 0x41 -> cmd_err in N+1, no btn_*, echo 0x3F,0x0A.
REQ-034 Three bytes 'M','R','C' back-to-back during echo -> 'M' processed, 'R' held in pend and processed next, 'C' dropped with one overrun pulse.
REQ-035 tx_busy tied 0 -> tx_start, then a cmd_err pulse after 16 cycles, then the second byte is attempted and times out too, then IDLE.
REQ-036 Assert reset in TX_WAIT with pend_valid=1 -> all outputs 0 immediately; no activity after release; ECHO_EN=0 run -> never tx_start.
